// File: rtl/mem_io_bridge.sv
// mem_io_bridge: MEM-stage bridge to data memory and board IO. Decodes each access,
// drives byte-lane stores, extracts and extends loads, stalls for data-memory read
// latency, and holds the LED / seven-segment registers plus synchronised switches.
module mem_io_bridge #(
    parameter int unsigned     DATA_W  = 32,
    parameter logic [DATA_W-1:0] IO_BASE = 32'hFFFF_FC00,
    parameter int unsigned     SW_W    = 16,
    parameter int unsigned     LED_W   = 16,
    parameter int unsigned     MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              acc_err,
    output logic              err_sticky,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [3:0]        dmem_we,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [SW_W-1:0]   sw_in,
    output logic [LED_W-1:0]  led_out,
    output logic [DATA_W-1:0] seg_data
);

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;
    localparam logic [2:0] LatInit = 3'(MEM_LAT - 1);

    localparam logic [DATA_W-1:0] OffSw  = 'h0;
    localparam logic [DATA_W-1:0] OffLed = 'h4;
    localparam logic [DATA_W-1:0] OffSeg = 'h8;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [DATA_W-1:0] seg_q, seg_d;
    logic              err_q, err_d;
    logic [SW_W-1:0]   sw_meta_q, sw_meta_d;
    logic [SW_W-1:0]   sw_sync_q, sw_sync_d;

    logic              access;
    logic              is_io;
    logic              misalign;
    logic              legal_rd;
    logic              legal_wr;
    logic [DATA_W-1:0] io_off;
    logic [DATA_W-1:0] io_rdata;
    logic [DATA_W-1:0] ld_val;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              rd_done;

    // Access decode and legality checks.
    always_comb begin
        access = req_valid & (mem_read | mem_write);
        is_io  = addr_in >= IO_BASE;
        io_off = addr_in - IO_BASE;
        case (size)
            SzByte:  misalign = 1'b0;
            SzHalf:  misalign = addr_in[0];
            SzWord:  misalign = addr_in[1:0] != 2'b00;
            default: misalign = 1'b1;
        endcase
        // IO registers only accept full-word accesses.
        acc_err  = access & ((mem_read & mem_write) | misalign | (is_io & (size != SzWord)));
        legal_rd = access & ~acc_err & mem_read;
        legal_wr = access & ~acc_err & mem_write;
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        dmem_addr  = {addr_in[DATA_W-1:2], 2'b00};
        dmem_we    = 4'b0000;
        dmem_wdata = wdata_in;
        case (size)
            SzByte: begin
                dmem_wdata = {4{wdata_in[7:0]}};
                dmem_we    = 4'b0001 << addr_in[1:0];
            end
            SzHalf: begin
                dmem_wdata = {2{wdata_in[15:0]}};
                dmem_we    = addr_in[1] ? 4'b1100 : 4'b0011;
            end
            default: dmem_we = 4'b1111;
        endcase
        if (!(legal_wr & ~is_io)) begin
            dmem_we = 4'b0000;
        end
    end

    // Byte/half extraction from the memory word with sign or zero extension.
    always_comb begin
        case (addr_in[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = addr_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size)
            SzByte:  ld_val = {{24{ld_byte[7] & ~load_unsigned}}, ld_byte};
            SzHalf:  ld_val = {{16{ld_half[15] & ~load_unsigned}}, ld_half};
            default: ld_val = dmem_rdata;
        endcase
    end

    // IO register read mux; unmapped offsets read as zero.
    always_comb begin
        io_rdata = '0;
        if (io_off == OffSw) begin
            io_rdata[SW_W-1:0] = sw_sync_q;
        end else if (io_off == OffLed) begin
            io_rdata[LED_W-1:0] = led_q;
        end else if (io_off == OffSeg) begin
            io_rdata = seg_q;
        end
    end

    // Read-latency FSM: stall from the request cycle until the counter expires.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        rd_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (legal_rd & ~is_io) begin
                    stall   = 1'b1;
                    state_d = StWait;
                    cnt_d   = LatInit;
                end
            end
            StWait: begin
                if (cnt_q != 3'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    rd_done = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // Load result: IO reads bypass extraction, memory reads appear once the wait ends.
    always_comb begin
        rdata = '0;
        if (legal_rd & is_io) begin
            rdata = io_rdata;
        end else if (legal_rd & rd_done) begin
            rdata = ld_val;
        end
    end

    // Next state of the IO registers, error latch and switch synchroniser.
    always_comb begin
        led_d     = led_q;
        seg_d     = seg_q;
        err_d     = err_q | acc_err;
        sw_meta_d = sw_in;
        sw_sync_d = sw_meta_q;
        if (legal_wr & is_io) begin
            if (io_off == OffLed) begin
                led_d = wdata_in[LED_W-1:0];
            end else if (io_off == OffSeg) begin
                seg_d = wdata_in;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            led_q     <= '0;
            seg_q     <= '0;
            err_q     <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
            seg_q     <= seg_d;
            err_q     <= err_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    assign led_out    = led_q;
    assign seg_data   = seg_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: three instances (MEM_LAT 2, 3, 1) share stimulus;
// `sel` picks the instance whose completed accesses the monitor checks.
module tb_mem_io_bridge;

    localparam logic [31:0] IoBase = 32'hFFFF_FC00;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, mem_read, mem_write, load_unsigned;
    logic [1:0]  size;
    logic [31:0] addr_in, wdata_in, dmem_rdata;
    logic [15:0] sw_in;

    logic [31:0] rdata_v [3];
    logic [31:0] daddr_v [3];
    logic [31:0] dwdata_v [3];
    logic [31:0] seg_v [3];
    logic [15:0] led_v [3];
    logic [3:0]  we_v [3];
    logic [2:0]  stall_v, err_v, sticky_v;

    always #5 clk = ~clk;

    mem_io_bridge #(.MEM_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .size(size), .load_unsigned(load_unsigned),
        .addr_in(addr_in), .wdata_in(wdata_in), .rdata(rdata_v[0]), .stall(stall_v[0]),
        .acc_err(err_v[0]), .err_sticky(sticky_v[0]), .dmem_addr(daddr_v[0]),
        .dmem_we(we_v[0]), .dmem_wdata(dwdata_v[0]), .dmem_rdata(dmem_rdata),
        .sw_in(sw_in), .led_out(led_v[0]), .seg_data(seg_v[0])
    );

    mem_io_bridge #(.MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .size(size), .load_unsigned(load_unsigned),
        .addr_in(addr_in), .wdata_in(wdata_in), .rdata(rdata_v[1]), .stall(stall_v[1]),
        .acc_err(err_v[1]), .err_sticky(sticky_v[1]), .dmem_addr(daddr_v[1]),
        .dmem_we(we_v[1]), .dmem_wdata(dwdata_v[1]), .dmem_rdata(dmem_rdata),
        .sw_in(sw_in), .led_out(led_v[1]), .seg_data(seg_v[1])
    );

    mem_io_bridge #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .size(size), .load_unsigned(load_unsigned),
        .addr_in(addr_in), .wdata_in(wdata_in), .rdata(rdata_v[2]), .stall(stall_v[2]),
        .acc_err(err_v[2]), .err_sticky(sticky_v[2]), .dmem_addr(daddr_v[2]),
        .dmem_we(we_v[2]), .dmem_wdata(dwdata_v[2]), .dmem_rdata(dmem_rdata),
        .sw_in(sw_in), .led_out(led_v[2]), .seg_data(seg_v[2])
    );

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] addr;
        bit          chk_rd;
        bit          chk_wd;
        int          stalls;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   sel = 0;
    int   tx_id = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: counts stall cycles of the selected instance and checks each completed access.
    initial begin
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && req_valid && (mem_read || mem_write)) begin
                if (stall_v[sel]) begin
                    stall_cnt++;
                end else if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_completion: got addr %h, expected none", addr_in);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("tx%0d_stalls", e.id), stall_cnt, e.stalls);
                    chk($sformatf("tx%0d_acc_err", e.id), {31'd0, err_v[sel]}, {31'd0, e.err});
                    chk($sformatf("tx%0d_dmem_we", e.id), {28'd0, we_v[sel]}, {28'd0, e.we});
                    chk($sformatf("tx%0d_dmem_addr", e.id), daddr_v[sel], e.addr);
                    if (e.chk_rd) chk($sformatf("tx%0d_rdata", e.id), rdata_v[sel], e.rdata);
                    if (e.chk_wd) chk($sformatf("tx%0d_wdata", e.id), dwdata_v[sel], e.wdata);
                    stall_cnt = 0;
                end
            end else begin
                stall_cnt = 0;
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mr,
                         input exp_t e);
        bit done;
        @(posedge clk);
        #1;
        req_valid = 1'b1; mem_read = rd; mem_write = wr; size = sz; load_unsigned = uns;
        addr_in = a; wdata_in = wd; dmem_rdata = mr;
        e.id   = tx_id++;
        e.addr = {a[31:2], 2'b00};
        sb_q.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!stall_v[sel]) done = 1'b1;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL tx%0d_timeout: got stall stuck high, expected completion", e.id);
        end
    endtask

    task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] mr, input logic [31:0] exp_rd, input int stalls);
        exp_t e;
        e = '{0, exp_rd, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0, stalls};
        issue(1'b1, 1'b0, sz, uns, a, 32'd0, mr, e);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] exp_we, input logic [31:0] exp_wd, input bit chk_wd);
        exp_t e;
        e = '{0, 32'd0, 1'b0, exp_we, exp_wd, 32'd0, 1'b0, chk_wd, 0};
        issue(1'b0, 1'b1, sz, 1'b0, a, wd, 32'd0, e);
    endtask

    task automatic bad(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e = '{0, 32'd0, 1'b1, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0, 0};
        issue(rd, wr, sz, 1'b0, a, wd, 32'hCAFE_F00D, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b10;
        load_unsigned = 1'b0; addr_in = 32'd0; wdata_in = 32'd0; dmem_rdata = 32'd0;
        sw_in = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        // A legal memory read during reset must not stall.
        req_valid = 1'b1; mem_read = 1'b1;
        #1;
        chk("rst_stall_forced", {31'd0, stall_v[0]}, 32'd0);
        chk("rst_led", {16'd0, led_v[0]}, 32'd0);
        chk("rst_seg", seg_v[0], 32'd0);
        chk("rst_sticky", {31'd0, sticky_v[0]}, 32'd0);
        req_valid = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // MEM_LAT = 2 instance.
        sel = 0;
        ld(2'b00, 1'b0, 32'h0000_0013, 32'h80FF_1234, 32'hFFFF_FF80, 2);
        ld(2'b00, 1'b1, 32'h0000_0013, 32'h80FF_1234, 32'h0000_0080, 2);
        ld(2'b01, 1'b0, 32'h0000_0012, 32'h80FF_1234, 32'hFFFF_80FF, 2);
        ld(2'b01, 1'b1, 32'h0000_0010, 32'h80FF_1234, 32'h0000_1234, 2);
        ld(2'b00, 1'b0, 32'h0000_0010, 32'h80FF_1234, 32'h0000_0034, 2);
        ld(2'b10, 1'b0, 32'h0000_0004, 32'h80FF_1234, 32'h80FF_1234, 2);
        st(2'b01, 32'h0000_0022, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF, 1'b1);
        st(2'b00, 32'h0000_0001, 32'hDEAD_BEEF, 4'b0010, 32'hEFEF_EFEF, 1'b1);
        st(2'b10, 32'h0000_0008, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b1);

        st(2'b10, IoBase + 32'h4, 32'h0001_A5A5, 4'b0000, 32'd0, 1'b0);
        chk("led_same_cycle_old", {16'd0, led_v[0]}, 32'd0);
        idle(1);
        chk("led_after_edge", {16'd0, led_v[0]}, 32'h0000_A5A5);
        ld(2'b10, 1'b0, IoBase + 32'h4, 32'd0, 32'h0000_A5A5, 0);
        st(2'b10, IoBase + 32'h8, 32'h1234_5678, 4'b0000, 32'd0, 1'b0);
        ld(2'b10, 1'b0, IoBase + 32'h8, 32'd0, 32'h1234_5678, 0);
        ld(2'b10, 1'b0, IoBase + 32'hC, 32'hFFFF_FFFF, 32'd0, 0);

        idle(1);
        sw_in = 16'h00F0;
        @(posedge clk);
        ld(2'b10, 1'b0, IoBase, 32'd0, 32'h0000_00F0, 0);

        chk("sticky_before_err", {31'd0, sticky_v[0]}, 32'd0);
        bad(1'b1, 1'b0, 2'b10, 32'h0000_0006, 32'd0);
        chk("sticky_same_cycle", {31'd0, sticky_v[0]}, 32'd0);
        idle(1);
        chk("sticky_set", {31'd0, sticky_v[0]}, 32'd1);
        bad(1'b0, 1'b1, 2'b01, IoBase + 32'h8, 32'h0000_FFFF);
        idle(1);
        chk("seg_unchanged", seg_v[0], 32'h1234_5678);
        bad(1'b1, 1'b1, 2'b10, 32'h0000_0000, 32'd0);
        bad(1'b1, 1'b0, 2'b11, 32'h0000_0000, 32'd0);
        bad(1'b1, 1'b0, 2'b01, 32'h0000_0003, 32'd0);
        bad(1'b0, 1'b1, 2'b10, 32'h0000_0002, 32'h1111_1111);
        idle(4);

        // MEM_LAT = 1 instance: back-to-back word reads.
        sel = 2;
        ld(2'b10, 1'b0, 32'h0000_0000, 32'h1111_2222, 32'h1111_2222, 1);
        ld(2'b10, 1'b0, 32'h0000_0004, 32'h3333_4444, 32'h3333_4444, 1);
        idle(4);

        // MEM_LAT = 3 instance: reset during the second wait cycle.
        sel = 1;
        st(2'b10, IoBase + 32'h4, 32'h0000_5A5A, 4'b0000, 32'd0, 1'b0);
        idle(1);
        chk("lat3_led_pre", {16'd0, led_v[1]}, 32'h0000_5A5A);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'b10;
        addr_in = 32'h0000_0040; dmem_rdata = 32'hABCD_0123;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("lat3_stall_wait2", {31'd0, stall_v[1]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midwait_stall", {31'd0, stall_v[1]}, 32'd0);
        chk("midwait_led", {16'd0, led_v[1]}, 32'd0);
        chk("midwait_seg", seg_v[1], 32'd0);
        chk("midwait_sticky", {31'd0, sticky_v[1]}, 32'd0);
        req_valid = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        ld(2'b10, 1'b0, 32'h0000_0040, 32'hABCD_0123, 32'hABCD_0123, 3);
        idle(2);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Parametrised memory/IO bridge between the MEM stage and the data memory and board peripherals. It decodes each access as data memory or memory-mapped IO and generates byte-lane write enables for `sb`/`sh`/`sw`. It sign- or zero-extends `lb`/`lbu`/`lh`/`lhu` loads, stalls the pipeline for a configurable data-memory read latency, and holds the LED and seven-segment output registers. Switch inputs are two-flop synchronised, and misaligned or illegal accesses are flagged.

## Interface
- `DATA_W`, 32, datapath and address width (fixed 32 in this generation)
- `IO_BASE`, 32'hFFFF_FC00, addresses ≥ `IO_BASE` are IO; all others are data memory
- `SW_W`, 16, switch input width (1..32)
- `LED_W`, 16, LED output width (1..32)
- `MEM_LAT`, 1, data-memory read wait cycles (1..7)

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in 1: MEM-stage access request
- `mem_read` in 1: load
- `mem_write` in 1: store
- `size` in 2: access size; 00 byte, 01 half, 10 word, 11 illegal
- `load_unsigned` in 1: 1 = zero-extend, 0 = sign-extend
- `addr_in` in 32: ALU result address
- `wdata_in` in 32: store data from the register file
- `rdata` out 32: load result to write-back
- `stall` out 1: freeze the pipeline
- `acc_err` out 1: misaligned or illegal access in the current cycle
- `err_sticky` out 1: latched `acc_err`
- `dmem_addr` out 32: `{addr_in[31:2],2'b00}`
- `dmem_we` out 4: byte-lane write enables
- `dmem_wdata` out 32: lane-replicated store data
- `dmem_rdata` in 32: data-memory read word
- `sw_in` in `SW_W`: raw switches (asynchronous)
- `led_out` out `LED_W`: LED register
- `seg_data` out 32: value for the seven-segment driver

## Operation
- **Access detection**
  - Access = `req_valid & (mem_read | mem_write)`.
  - `mem_read & mem_write` both high is illegal.
- **Misalignment**: half at odd address, word with `addr_in[1:0]≠0`, or `size=11`.
- **Illegal or misaligned access**
  - `acc_err=1`.
  - `dmem_we=0`, no IO register update, `rdata=0`, no stall.
- **IO map** (offsets from `IO_BASE`)
  - +0x0: switches, read-only; returns `{0, sw_sync}`.
  - +0x4: LED; write loads `wdata_in[LED_W-1:0]`, read returns the LED value zero-extended.
  - +0x8: segment; write loads `wdata_in`, read returns `seg_data`.
  - Other IO offsets: read returns 0, write is ignored.
  - IO accesses must be word size; otherwise the access is illegal.
- **Store lanes**
  - sb: `dmem_we = 1<<addr[1:0]`, `dmem_wdata = {4{wdata_in[7:0]}}`.
  - sh: `dmem_we = addr[1] ? 4'b1100 : 4'b0011`, `dmem_wdata = {2{wdata_in[15:0]}}`.
  - sw: `dmem_we = 4'b1111`.
  - `dmem_we` is 0 for IO addresses.
- **Load extraction**
  - Select byte/half from `dmem_rdata` by `addr[1:0]`.
  - Extend per `load_unsigned`.
  - IO reads bypass extraction.
- **Read FSM**
  - States: IDLE, WAIT; counter `cnt` is 3 bits.
  - IDLE + legal memory read: `stall=1`; next state WAIT with `cnt=MEM_LAT-1`.
  - WAIT with `cnt≠0`: `stall=1`, `cnt--`.
  - WAIT with `cnt=0`: `stall=0`, `rdata` valid; next state IDLE.
  - Stores, IO reads and IO writes complete in the request cycle without stalling.
- **Request stability**: the requester holds `req_valid`, address, size and data stable while `stall=1`. Changing them is undefined except under reset.
- **Error latch**: `err_sticky` sets on any `acc_err` edge; only `rst` clears it.

## Timing
- **Reset values**
  - FSM = IDLE, `cnt=0`.
  - `led_out=0`, `seg_data=0`, `sw_sync` stages = 0, `err_sticky=0`.
  - `stall` is forced to 0 while `rst` is high.
  - `rdata` is combinational.
- **Memory read latency**: request in cycle 0; `stall` high in cycles 0..`MEM_LAT-1`; `rdata` valid in cycle `MEM_LAT`.
- **Back-to-back memory reads**: each read restarts from IDLE; no stall-free overlap.
- **IO writes**: `led_out`/`seg_data` update at the edge ending the request cycle. A same-cycle read of that register returns the old value.
- **Switch path**: `sw_in` reaches readable `rdata` 2 edges after it changes.
- **Reset in WAIT**: asynchronous return to IDLE; `stall` drops immediately and no write-back occurs.
- **Combinational paths**: `dmem_we`, `dmem_wdata`, `acc_err` and `rdata` are combinational in the request cycle.

## Test plan
- **Byte load, sign-extended**: `MEM_LAT=2`; lb at 0x0000_0013, `dmem_rdata=0x80FF_1234` → `stall` high 2 cycles, then `rdata=0xFFFF_FF80`. Same with lbu → `0x0000_0080`.
- **Store lanes**
  - sh at 0x0000_0022, `wdata_in=0xDEAD_BEEF` → `dmem_we=1100`, `dmem_wdata=0xBEEF_BEEF`, no stall.
  - sb at 0x0000_0001 → `dmem_we=0010`.
- **IO write/read**
  - sw to `IO_BASE+4`, `wdata_in=0x0001_A5A5` → `led_out=0xA5A5` after 1 edge.
  - lw from `IO_BASE+4` → `rdata=0x0000_A5A5`, no stall.
  - `sw_in=0x00F0` held 2 edges, then lw from `IO_BASE` → `0x0000_00F0`.
- **Errors**
  - lw at 0x0000_0006 → `acc_err=1`, `rdata=0`, no stall, `err_sticky=1` next cycle.
  - sh to `IO_BASE+8` → `seg_data` unchanged, `acc_err=1`.
  - read+write together → `acc_err=1`.
- **Reset mid-wait**: `MEM_LAT=3`; assert `rst` during the second WAIT cycle → `stall=0` immediately, `led_out`/`seg_data`/`err_sticky` = 0. After release, a new lw stalls a full 3 cycles.
- **Back-to-back reads**: two consecutive lw, `MEM_LAT=1` → `stall` pattern 1,0,1,0; each `rdata` matches its `dmem_rdata`.
